// File: rtl/jtframe_rom_pkg.sv
// Shared definitions for the N-slot ROM arbiter: FSM states, default
// address width and a helper to build the packed per-slot offset vector.
package jtframe_rom_pkg;

  localparam int SAW_DEF = 22;
  // Widest packed offset vector the helper can build (16 slots x 32 bits).
  localparam int PACK_W  = 512;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DATA = 2'd2
  } rom_state_e;

  // Place a saw-bit offset for slot k into an accumulated packed vector.
  function automatic logic [PACK_W-1:0] pack_offset(
    input logic [PACK_W-1:0] acc,
    input int                k,
    input int                saw,
    input logic [31:0]       off
  );
    logic [PACK_W-1:0] mask;
    logic [PACK_W-1:0] v;
    mask = (PACK_W'(1) << saw) - PACK_W'(1);
    v    = (PACK_W'(off) & mask) << (k * saw);
    return acc | v;
  endfunction

endpackage

// File: rtl/jtframe_rom_rrarb.sv
// Request arbiter: scans the request vector starting at a pointer (round
// robin) or at slot 0 (fixed priority) and returns the first hit.
module jtframe_rom_rrarb #(
  parameter int SLOTS = 8,
  parameter bit RR    = 1'b1,
  parameter int IW    = 3
) (
  input  logic [SLOTS-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [SLOTS-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             gnt_any
);

  logic [IW-1:0] start;

  // Fixed priority simply forces the scan to begin at slot 0.
  assign start = ptr & {IW{RR}};

  // Walk the slots from the farthest to the nearest so the nearest
  // requester after start overwrites any earlier candidate.
  always_comb begin
    int            idx;
    logic [IW-1:0] ix;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    ix      = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= SLOTS) idx = idx - SLOTS;
      ix = IW'(idx);
      if (req[ix]) begin
        gnt     = '0;
        gnt[ix] = 1'b1;
        gnt_idx = ix;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtframe_rom_nslot.sv
// N-slot SDRAM read arbiter with a one-word cache per slot. Hits are served
// combinationally from the cache; misses are fetched one at a time over the
// single SDRAM read port.
//
// SDRAM handshake: sdram_req rises with a stable sdram_addr and is held until
// the cycle sdram_ack is sampled high; after that exactly one data_rdy pulse
// carries the word. data_rdy outside the data phase is ignored.
module jtframe_rom_nslot
  import jtframe_rom_pkg::*;
#(
  parameter int                   SLOTS   = 8,
  parameter int                   SAW     = SAW_DEF,
  parameter logic [SLOTS*SAW-1:0] OFFSETS = '0,
  parameter logic [SLOTS-1:0]     DW8     = '0,
  parameter bit                   RR      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 downloading,
  input  logic [SLOTS-1:0]     slot_cs,
  input  logic [SLOTS*SAW-1:0] slot_addr,
  output logic [SLOTS-1:0]     slot_ok,
  output logic [SLOTS*16-1:0]  slot_dout,
  output logic                 sdram_req,
  output logic [SAW-1:0]       sdram_addr,
  input  logic                 sdram_ack,
  input  logic                 data_rdy,
  input  logic [15:0]          data_read,
  output rom_state_e           st_dbg
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  rom_state_e       state, st_nx;
  logic [SLOTS-1:0] valid;
  logic [SAW-1:0]   tag  [SLOTS];
  logic [15:0]      data [SLOTS];
  logic [SAW-1:0]   wa   [SLOTS];
  logic [SAW-1:0]   offs [SLOTS];
  logic [SLOTS-1:0] miss;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    gnt_q;
  logic [SAW-1:0]   tag_pend;
  logic [SLOTS-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [SAW-1:0]   sel_off;
  logic [SAW-1:0]   sel_wa;

  assign st_dbg = state;

  // Per-slot address decode, hit detection and data steering.
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    logic [SAW-1:0] addr_k;
    assign addr_k  = slot_addr[k*SAW +: SAW];
    assign offs[k] = OFFSETS[k*SAW +: SAW];
    if (DW8[k]) begin : g_byte
      assign wa[k] = {1'b0, addr_k[SAW-1:1]};
      assign slot_dout[k*16 +: 16] = {8'h00, addr_k[0] ? data[k][15:8] : data[k][7:0]};
    end else begin : g_word
      assign wa[k] = addr_k;
      assign slot_dout[k*16 +: 16] = data[k];
    end
    assign slot_ok[k] = slot_cs[k] & valid[k] & (tag[k] == wa[k]);
    assign miss[k]    = slot_cs[k] & ~slot_ok[k] & ~downloading;
  end

  jtframe_rom_rrarb #(
    .SLOTS (SLOTS),
    .RR    (RR),
    .IW    (IW)
  ) u_arb (
    .req     (miss),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // One-hot select of the granted slot's offset and word address.
  always_comb begin
    sel_off = '0;
    sel_wa  = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (gnt[k]) begin
        sel_off = sel_off | offs[k];
        sel_wa  = sel_wa | wa[k];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= st_nx;
  end

  // FSM next state; a ROM download aborts whatever is in flight.
  always_comb begin
    st_nx = state;
    if (downloading) begin
      st_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (gnt_any)   st_nx = ST_WAIT_ACK;
        ST_WAIT_ACK:  if (sdram_ack) st_nx = ST_WAIT_DATA;
        ST_WAIT_DATA: if (data_rdy)  st_nx = ST_IDLE;
        default:                     st_nx = ST_IDLE;
      endcase
    end
  end

  // Request issue, pointer update and cache fill. The fill always writes
  // the tag latched at grant time, even if the slot address moved since.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      gnt_q      <= '0;
      tag_pend   <= '0;
      rr_ptr     <= '0;
      valid      <= '0;
      for (int k = 0; k < SLOTS; k++) begin
        tag[k]  <= '0;
        data[k] <= '0;
      end
    end else if (downloading) begin
      sdram_req <= 1'b0;
      valid     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            sdram_addr <= sel_off + sel_wa;
            sdram_req  <= 1'b1;
            gnt_q      <= gnt_idx;
            tag_pend   <= sel_wa;
            rr_ptr     <= (gnt_idx == IW'(SLOTS - 1)) ? '0 : gnt_idx + 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (sdram_ack) sdram_req <= 1'b0;
        end
        ST_WAIT_DATA: begin
          if (data_rdy) begin
            tag[gnt_q]   <= tag_pend;
            data[gnt_q]  <= data_read;
            valid[gnt_q] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
